// File: rtl/icache_nway_if.sv
// Fetch-side and refill-side signal bundle for icache_nway.
// slave is the cache's view; master is the fetch stage / memory controller view.
interface icache_nway_if #(
  parameter int unsigned BEAT_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_req_addr;
  logic              mem_resp_valid;
  logic [BEAT_W-1:0] mem_resp_data;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with tree-PLRU replacement.
// Blocking: one outstanding fetch; misses refill a whole line beat by beat,
// then answer the fetch. Supports whole-cache flush and hit/miss counters.
module icache_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned BEAT_W     = 64
) (
  input logic          clk,
  input logic          rst,
  icache_nway_if.slave bus
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 64 - OFF_W - IDX_W;
  localparam int unsigned BEATS  = LINE_BYTES * 8 / BEAT_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BOFF_W = $clog2(BEAT_W / 8);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLookup  = 3'd1;
  localparam logic [2:0] StMissReq = 3'd2;
  localparam logic [2:0] StRefill  = 3'd3;
  localparam logic [2:0] StResp    = 3'd4;
  localparam logic [2:0] StFlush   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [BEAT_W-1:0] data_q  [WAYS][SETS][BEATS];
  // Index 0 unused; node n has children 2n and 2n+1.
  logic [WAYS-1:0]   plru_q  [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [CNT_W-1:0] beat_sel;
  logic             word_hi;
  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             lookup_hit, lookup_miss, refill_beat, fill_done;

  // Make every tree node on the path to `way` point at the opposite subtree.
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAY_W:0] node;
    node = (WAY_W+1)'(1);
    for (int l = WAY_W - 1; l >= 0; l--) begin
      bits[node[WAY_W-1:0]] = ~way[l];
      node = {node[WAY_W-1:0], way[l]};
    end
    return bits;
  endfunction

  function automatic logic [31:0] sel_word(input logic [BEAT_W-1:0] b, input logic hi);
    if (hi) return b[BEAT_W-1 -: 32];
    else    return b[31:0];
  endfunction

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[63 -: TAG_W];
  assign beat_sel = CNT_W'(addr_q[OFF_W-1:0] >> BOFF_W);
  assign word_hi  = (BEAT_W == 64) && addr_q[2];

  assign lookup_hit  = (state_q == StLookup) && (|hit_vec);
  assign lookup_miss = (state_q == StLookup) && !(|hit_vec);
  assign refill_beat = (state_q == StRefill) && bus.mem_resp_valid;
  assign fill_done   = refill_beat && (beat_q == LastBeat);

  // Tag compare across all ways of the latched set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way first, otherwise walk the PLRU tree.
  always_comb begin
    logic [WAY_W:0]  node;
    logic [WAYS-1:0] bits;
    logic            found;
    bits   = plru_q[idx];
    node   = (WAY_W+1)'(1);
    victim = '0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      victim[l] = bits[node[WAY_W-1:0]];
      node      = {node[WAY_W-1:0], victim[l]};
    end
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[w][idx]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  // Control FSM next-state and response/counter updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.flush) begin
          state_d = StFlush;
        end else if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (|hit_vec) begin
          resp_valid_d = 1'b1;
          resp_data_d  = sel_word(data_q[hit_way][idx][beat_sel], word_hi);
          hit_cnt_d    = hit_cnt_q + 32'd1;
          state_d      = StIdle;
        end else begin
          victim_d   = victim;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = StMissReq;
        end
      end
      StMissReq: begin
        if (bus.mem_req_ready) begin
          beat_d  = '0;
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (bus.mem_resp_valid) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == LastBeat) begin
            // The requested word may be arriving in this very beat.
            resp_valid_d = 1'b1;
            resp_data_d  = sel_word((beat_sel == beat_q) ? bus.mem_resp_data
                                                         : data_q[victim_q][idx][beat_sel],
                                    word_hi);
            state_d      = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Valid and PLRU state; the victim is invalidated as soon as it is chosen.
  always_ff @(posedge clk) begin
    if (rst || (state_q == StFlush)) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (lookup_hit) begin
      plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
    end else if (lookup_miss) begin
      valid_q[victim][idx] <= 1'b0;
    end else if (fill_done) begin
      valid_q[victim_q][idx] <= 1'b1;
      plru_q[idx]            <= plru_touch(plru_q[idx], victim_q);
    end
  end

  // Refill beats land directly in the victim line; the tag goes in with the last beat.
  always_ff @(posedge clk) begin
    if (refill_beat) data_q[victim_q][idx][beat_q] <= bus.mem_resp_data;
    if (fill_done)   tag_q[victim_q][idx] <= tag;
  end

  // A tag can only ever be resident in one way of a set.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StLookup)) begin
      assert ($onehot0(hit_vec)) else $error("icache_nway: more than one way hit");
    end
  end

  assign bus.req_ready     = (state_q == StIdle) && !bus.flush;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.mem_req_valid = (state_q == StMissReq);
  assign bus.mem_req_addr  = (state_q == StMissReq) ? {addr_q[63:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.hit_count     = hit_cnt_q;
  assign bus.miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: a 4-way/64B-line/64-bit-beat instance and an
// 8-way/32B-line/32-bit-beat instance sharing one set of stimulus signals.
module tb_icache_nway;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_nway_if #(.BEAT_W(64)) ifa ();
  icache_nway_if #(.BEAT_W(32)) ifb ();

  icache_nway #(.WAYS(4), .SETS(64), .LINE_BYTES(64), .BEAT_W(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  icache_nway #(.WAYS(8), .SETS(16), .LINE_BYTES(32), .BEAT_W(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Shared stimulus, steered to one instance by sel.
  logic        sel;
  logic        t_req_valid, t_flush, t_mem_req_ready, t_mem_resp_valid;
  logic [63:0] t_req_addr, t_beat;

  assign ifa.req_valid      = t_req_valid & ~sel;
  assign ifa.req_addr       = t_req_addr;
  assign ifa.flush          = t_flush & ~sel;
  assign ifa.mem_req_ready  = t_mem_req_ready & ~sel;
  assign ifa.mem_resp_valid = t_mem_resp_valid & ~sel;
  assign ifa.mem_resp_data  = t_beat;
  assign ifb.req_valid      = t_req_valid & sel;
  assign ifb.req_addr       = t_req_addr;
  assign ifb.flush          = t_flush & sel;
  assign ifb.mem_req_ready  = t_mem_req_ready & sel;
  assign ifb.mem_resp_valid = t_mem_resp_valid & sel;
  assign ifb.mem_resp_data  = t_beat[31:0];

  logic        o_req_ready, o_resp_valid, o_mem_req_valid;
  logic [31:0] o_resp_data, o_hit_count, o_miss_count;
  logic [63:0] o_mem_req_addr;
  assign o_req_ready     = sel ? ifb.req_ready     : ifa.req_ready;
  assign o_resp_valid    = sel ? ifb.resp_valid    : ifa.resp_valid;
  assign o_resp_data     = sel ? ifb.resp_data     : ifa.resp_data;
  assign o_mem_req_valid = sel ? ifb.mem_req_valid : ifa.mem_req_valid;
  assign o_mem_req_addr  = sel ? ifb.mem_req_addr  : ifa.mem_req_addr;
  assign o_hit_count     = sel ? ifb.hit_count     : ifa.hit_count;
  assign o_miss_count    = sel ? ifb.miss_count    : ifa.miss_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] cur_addr;
  int          exp_hits [2];
  int          exp_miss [2];

  typedef struct {
    logic [63:0] addr;
    bit          miss;
    bit          use_b;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [63:0] a, input bit m, input bit b);
    vec_t v;
    v.addr = a; v.miss = m; v.use_b = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (addr %h): got %h, expected %h", name, cur_addr, act, exp);
    end
  endtask

  // Backing-store contents: the 0x8000_0000 line's first beat is 0x1111_2222_3333_4444.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    logic [63:0] wa;
    wa = {a[63:2], 2'b00};
    if (wa == 64'h8000_0000) return 32'h3333_4444;
    if (wa == 64'h8000_0004) return 32'h1111_2222;
    return wa[31:0] ^ 32'hA5C3_0001;
  endfunction

  function automatic logic [63:0] beat_val(input logic [63:0] la, input int k, input logic b);
    if (b) return {32'h0, word_of(la + 64'(k) * 64'd4)};
    return {word_of(la + 64'(k) * 64'd8 + 64'd4), word_of(la + 64'(k) * 64'd8)};
  endfunction

  // One fetch, starting and ending at a falling edge. A miss is served as
  // a refill whatever was expected so the bench stays in step with the DUT.
  // abort_at >= 0 pulses reset just before that beat instead of finishing.
  task automatic fetch(input logic [63:0] a, input bit exp_m, input int stall, input int abort_at);
    int          n;
    bit          missed;
    logic [63:0] la;
    int          s;
    s        = sel ? 1 : 0;
    cur_addr = a;
    la       = sel ? (a & ~64'h1F) : (a & ~64'h3F);
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready before accept", o_req_ready, 1);
    t_req_valid = 1'b1;
    t_req_addr  = a;
    @(negedge clk);
    t_req_valid = 1'b0;
    t_req_addr  = 64'hDEAD_BEEF_0000_0000;
    check("resp_valid during lookup", o_resp_valid, 0);
    @(negedge clk);
    missed = o_mem_req_valid;
    check("hit/miss outcome", missed, exp_m);
    if (exp_m) exp_miss[s]++;
    else       exp_hits[s]++;
    if (missed) begin
      check("mem_req_addr", o_mem_req_addr, la);
      check("req_ready during miss", o_req_ready, 0);
      for (int i = 0; i < stall; i++) begin
        // Stray beats outside REFILL must be ignored.
        t_mem_resp_valid = 1'b1;
        t_beat           = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("mem_req_valid held in stall", o_mem_req_valid, 1);
        check("mem_req_addr stable in stall", o_mem_req_addr, la);
        check("req_ready low in stall", o_req_ready, 0);
      end
      t_mem_resp_valid = 1'b0;
      t_mem_req_ready  = 1'b1;
      @(negedge clk);
      t_mem_req_ready = 1'b0;
      check("mem_req_valid after handshake", o_mem_req_valid, 0);
      for (int k = 0; k < 8; k++) begin
        if (k == abort_at) begin
          t_mem_resp_valid = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          check("mem_req_valid after abort", o_mem_req_valid, 0);
          check("resp_valid after abort", o_resp_valid, 0);
          check("req_ready after abort", o_req_ready, 1);
          check("miss_count after abort", o_miss_count, 0);
          rst = 1'b0;
          exp_hits[0] = 0; exp_hits[1] = 0;
          exp_miss[0] = 0; exp_miss[1] = 0;
          return;
        end
        if (k == 3) begin
          // Idle gap mid-fill: the beat counter must hold.
          t_mem_resp_valid = 1'b0;
          t_beat           = 64'h0BAD_0BAD_0BAD_0BAD;
          @(negedge clk);
        end
        t_mem_resp_valid = 1'b1;
        t_beat           = beat_val(la, k, sel);
        @(negedge clk);
      end
      t_mem_resp_valid = 1'b0;
    end
    check("resp_valid", o_resp_valid, 1);
    check("resp_data", o_resp_data, word_of(a));
    if (!missed) check("req_ready in resp cycle", o_req_ready, 1);
    check("hit_count", o_hit_count, exp_hits[s]);
    check("miss_count", o_miss_count, exp_miss[s]);
    @(negedge clk);
    check("resp_valid single cycle", o_resp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    t_req_valid = 1'b0; t_flush = 1'b0; t_mem_req_ready = 1'b0; t_mem_resp_valid = 1'b0;
    t_req_addr = '0; t_beat = '0;
    cur_addr = '0;
    exp_hits[0] = 0; exp_hits[1] = 0;
    exp_miss[0] = 0; exp_miss[1] = 0;

    // 4-way: cold miss, hit, then PLRU sequence in set 0 (A..F at tag steps of 0x1000).
    add_vec(64'h8000_0004, 1, 0);  // cold miss -> way0
    add_vec(64'h8000_0000, 0, 0);  // hit
    add_vec(64'h8000_1000, 1, 0);  // B -> way1
    add_vec(64'h8000_2008, 1, 0);  // C -> way2
    add_vec(64'h8000_303C, 1, 0);  // D -> way3
    add_vec(64'h8000_0010, 0, 0);  // touch A
    add_vec(64'h8000_2000, 0, 0);  // touch C
    add_vec(64'h8000_4004, 1, 0);  // E evicts B
    add_vec(64'h8000_5000, 1, 0);  // F evicts D
    add_vec(64'h8000_0020, 0, 0);  // A still resident
    add_vec(64'h8000_2024, 0, 0);  // C still resident
    add_vec(64'h8000_4000, 0, 0);  // E resident
    add_vec(64'h8000_5038, 0, 0);  // F resident
    add_vec(64'h8000_1000, 1, 0);  // B was evicted
    // 8-way, 32-bit beats: fill one line, then read every word offset.
    add_vec(64'h4000_0014, 1, 1);
    for (int i = 0; i < 8; i++) add_vec(64'h4000_0000 + 64'(i) * 64'd4, 0, 1);
    add_vec(64'h4000_0020, 1, 1);

    repeat (3) @(negedge clk);
    check("reset req_ready", ifa.req_ready, 1);
    check("reset resp_valid", ifa.resp_valid, 0);
    check("reset resp_data", ifa.resp_data, 0);
    check("reset mem_req_valid", ifa.mem_req_valid, 0);
    check("reset mem_req_addr", ifa.mem_req_addr, 0);
    check("reset hit_count", ifa.hit_count, 0);
    check("reset miss_count", ifa.miss_count, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      sel = vecs[i].use_b;
      fetch(vecs[i].addr, vecs[i].miss, 0, -1);
    end
    sel = 1'b0;
    @(negedge clk);

    // Flush in IDLE with a competing request: request must be ignored.
    cur_addr    = 64'h8000_2000;
    t_flush     = 1'b1;
    t_req_valid = 1'b1;
    t_req_addr  = 64'h8000_2000;
    #1;
    check("req_ready while flush", o_req_ready, 0);
    @(negedge clk);
    t_flush     = 1'b0;
    t_req_valid = 1'b0;
    check("req_ready in flush state", o_req_ready, 0);
    check("no resp during flush", o_resp_valid, 0);
    @(negedge clk);
    check("req_ready after flush", o_req_ready, 1);
    check("miss_count unchanged by flush", o_miss_count, exp_miss[0]);
    fetch(64'h8000_0000, 1, 0, -1);  // previously resident, now gone
    fetch(64'h8000_2000, 1, 0, -1);

    // Refill stall, then reset after beat 3; the line must not survive.
    fetch(64'h8000_0040, 1, 5, 4);
    @(negedge clk);
    fetch(64'h8000_0044, 1, 0, -1);
    fetch(64'h8000_0048, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache with tree-PLRU replacement.
- Sits between the fetch stage and the AXI read controller.
- Accepts 32-bit fetches on a valid/ready request port and returns hits one cycle later.
- On a miss, refills a whole line over a beat-wise memory port, then answers the fetch.
- Adds a whole-cache flush (fence.i) and hit/miss counters.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 64, lines per way; power of two.
- LINE_BYTES, 64, bytes per line; power of two, at least BEAT_W/8.
- BEAT_W, 64, memory beat width in bits; 32 or 64.
- Derived values:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(SETS)
  - TAG_W = 64-OFF_W-IDX_W
  - BEATS = LINE_BYTES*8/BEAT_W

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  cache can accept a request.
- req_addr  in  64  fetch byte address; bits [1:0] ignored.
- resp_valid  out  1  one-cycle pulse, resp_data valid.
- resp_data  out  32  fetched instruction word.
- flush  in  1  invalidate all lines (level, sampled in IDLE).
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_addr  out  64  line-aligned address (low OFF_W bits zero).
- mem_resp_valid  in  1  refill beat valid; no backpressure.
- mem_resp_data  in  BEAT_W  refill beat; beat k holds line bytes k*BEAT_W/8 upward, little-endian.
- hit_count  out  32  wrapping count of hit lookups.
- miss_count  out  32  wrapping count of miss lookups.

Behaviour:
- Storage:
  - Per way: tag array, valid bits (flops), data array (SETS x LINE_BYTES).
  - Per set: WAYS-1 PLRU bits. Node 1 is the root; children of node n are 2n and 2n+1. Bit=0 points to the left subtree as the victim side.
- Reset:
  - All valid bits and PLRU bits cleared; state IDLE.
  - req_ready=1, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0, counters=0.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH.
- IDLE:
  - req_ready = !flush.
  - If flush=1: go to FLUSH, ignoring req_valid.
  - Else on req_valid: latch addr, go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the tag across all ways at the latched index; at most one way may hit (verification assertion).
  - Hit:
    - resp_valid=1 next cycle, with the word at addr[OFF_W-1:2] of the hit way.
    - Update PLRU so every node on the path points away from the hit way.
    - hit_count+1; return to IDLE. Back-to-back accept is allowed in the response cycle.
  - Miss:
    - Victim = lowest-index invalid way if any, else the PLRU-tree walk from the root.
    - Latch the victim; miss_count+1; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = latched addr with low OFF_W bits zeroed.
  - Hold both stable until mem_req_ready; then go to REFILL with beat counter = 0.
- REFILL:
  - Each mem_resp_valid writes beat[counter] into the victim line and increments the counter.
  - Valid bit stays 0 during the fill.
  - After beat BEATS-1: set tag and valid, update PLRU as for a hit on the victim, go to RESP.
- RESP:
  - resp_valid=1 with the requested word from the refilled line; go to IDLE.
  - Refill-to-response latency is exactly 1 cycle after the last beat.
- FLUSH (1 cycle):
  - Clear all valid and PLRU bits; return to IDLE.
  - flush held high re-enters FLUSH; no request is accepted while flush=1.
- Boundaries:
  - flush in non-IDLE states is ignored; the caller holds it until req_ready.
  - mem_resp_valid outside REFILL is ignored.
  - Reset mid-refill aborts the fill: line stays invalid, mem_req_valid drops that cycle. The memory side is reset with the cache.
  - Counters wrap 0xFFFFFFFF -> 0.
- Throughput: hit = 1 request every 2 cycles; resp_valid is never asserted 2 consecutive cycles.

Test Plan:
- Cold miss: reset, request 0x8000_0004 → mem_req_addr=0x8000_0000; 8 beats with beat0=0x1111_2222_3333_4444 → resp_data=0x1111_2222, miss_count=1.
- Hit after fill: request 0x8000_0000 → resp_valid 2 cycles after the accept edge, data 0x3333_4444, no mem_req_valid, hit_count=1.
- PLRU (WAYS=4):
  - Fill tags A,B,C,D in set 0 (invalid-first fill order way0..3).
  - Touch A, C, then miss E → E replaces way1 (B).
  - Then miss F → F replaces way3 (D).
- Flush: after fills, flush=1 for 1 cycle in IDLE → req_ready=0 that cycle; the next request to 0x8000_0000 misses, miss_count+1.
- Stall and reset: mem_req_ready held 0 for 5 cycles → mem_req_addr stable and req_ready=0 throughout. Assert rst after beat 3 → mem_req_valid=0, and a re-request of the same address misses again.
- Parameter sweep: WAYS=2/8, LINE_BYTES=32, BEAT_W=32 → correct beat count (8) and word selection across all offsets 0..28.
